// File: rtl/othello_draw_pkg.sv
// rtl/othello_draw_pkg.sv - shared colour, select and state encodings for the cell renderer
package othello_draw_pkg;

    // 3-bit RGB, one bit per channel
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] WHITE  = 3'b111;

    // Cell draw select codes
    localparam logic [1:0] SEL_EMPTY  = 2'd0;
    localparam logic [1:0] SEL_BOX    = 2'd1;
    localparam logic [1:0] SEL_DISK_B = 2'd2;
    localparam logic [1:0] SEL_DISK_W = 2'd3;

    // Renderer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/cell_pixel_colour.sv
// rtl/cell_pixel_colour.sv - combinational colour of one pixel inside a cell
//
// Ports:
//   i_dx, i_dy  pixel offset inside the cell (0..CELL-1)
//   i_select    0 empty, 1 cursor box, 2 black disk, 3 white disk
//   o_colour    3-bit RGB colour for that pixel
module cell_pixel_colour
    import othello_draw_pkg::*;
#(
    parameter int CELL   = 12,
    parameter int DISK_D = 10,
    parameter int DW     = $clog2(CELL)
) (
    input  logic [DW-1:0] i_dx,
    input  logic [DW-1:0] i_dy,
    input  logic [1:0]    i_select,
    output logic [2:0]    o_colour
);

    localparam logic [DW-1:0]     LAST  = DW'(CELL - 1);
    localparam logic signed [31:0] C_OFF = 32'(CELL - 1);
    localparam logic signed [31:0] R2    = 32'(DISK_D * DISK_D);

    // Doubled coordinates put the cell centre on an integer grid point,
    // so an even-sized cell gets a symmetric disk without fractions.
    logic signed [31:0] w_a;
    logic signed [31:0] w_b;
    logic signed [31:0] w_r2;
    logic               w_edge;
    logic               w_inside;

    assign w_a      = $signed({{(31 - DW){1'b0}}, i_dx, 1'b0}) - C_OFF;
    assign w_b      = $signed({{(31 - DW){1'b0}}, i_dy, 1'b0}) - C_OFF;
    assign w_r2     = w_a * w_a + w_b * w_b;
    assign w_inside = (w_r2 <= R2);
    assign w_edge   = (i_dx == '0) || (i_dx == LAST) || (i_dy == '0) || (i_dy == LAST);

    always_comb begin
        o_colour = GREEN;
        case (i_select)
            SEL_BOX:    if (w_edge)   o_colour = YELLOW;
            SEL_DISK_B: if (w_inside) o_colour = BLACK;
            SEL_DISK_W: if (w_inside) o_colour = WHITE;
            default:    o_colour = GREEN;
        endcase
    end

endmodule

// File: rtl/cell_drawer.sv
// rtl/cell_drawer.sv - scans one board cell row-major, one pixel per clock, into the VGA adapter
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-high reset
//   start                  draw request, sampled only while idle
//   x_base, y_base         pixel origin of the cell's top-left corner
//   select                 0 empty, 1 cursor box, 2 black disk, 3 white disk
//   vga_x, vga_y           pixel coordinate (wraps at 256 / 128)
//   vga_colour, vga_plot   colour and write enable; coordinates valid only with vga_plot
//   busy, done             busy from accept through the done cycle; done is a one-cycle pulse
module cell_drawer
    import othello_draw_pkg::*;
#(
    parameter int CELL   = 12,
    parameter int DISK_D = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_base,
    input  logic [6:0] y_base,
    input  logic [1:0] select,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam int            DW   = $clog2(CELL);
    localparam logic [DW-1:0] LAST = DW'(CELL - 1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_dx;
    logic [DW-1:0] r_dy;
    logic [7:0]    r_x_base;
    logic [6:0]    r_y_base;
    logic [1:0]    r_select;
    logic [7:0]    r_vga_x;
    logic [6:0]    r_vga_y;
    logic [2:0]    r_vga_colour;
    logic          r_vga_plot;
    logic          r_busy;
    logic          r_done;
    logic [2:0]    w_colour;

    cell_pixel_colour #(
        .CELL   (CELL),
        .DISK_D (DISK_D),
        .DW     (DW)
    ) u_colour (
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_select (r_select),
        .o_colour (w_colour)
    );

    // Reset is asynchronous so an abort drops vga_plot without waiting for a clock.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state      <= ST_IDLE;
            r_dx         <= '0;
            r_dy         <= '0;
            r_x_base     <= '0;
            r_y_base     <= '0;
            r_select     <= SEL_EMPTY;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done     <= 1'b0;
                    r_vga_plot <= 1'b0;
                    if (start) begin
                        r_x_base <= x_base;
                        r_y_base <= y_base;
                        r_select <= select;
                        r_dx     <= '0;
                        r_dy     <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_DRAW;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    r_vga_x      <= r_x_base + 8'(r_dx);
                    r_vga_y      <= r_y_base + 7'(r_dy);
                    r_vga_colour <= w_colour;
                    r_vga_plot   <= 1'b1;
                    if (r_dx == LAST) begin
                        r_dx <= '0;
                        if (r_dy == LAST) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_dy <= r_dy + 1'b1;
                        end
                    end else begin
                        r_dx <= r_dx + 1'b1;
                    end
                end
                ST_FIN: begin
                    // busy stays high through the done cycle; IDLE clears it
                    r_vga_plot <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_cell_drawer.sv
// tb/tb_cell_drawer.sv - scoreboard bench for cell_drawer
module tb_cell_drawer;
    import othello_draw_pkg::*;

    logic       clock  = 1'b0;
    logic       resetn = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] x_base = '0;
    logic [6:0] y_base = '0;
    logic [1:0] select = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    always #5 clock = ~clock;

    cell_drawer #(.CELL(12), .DISK_D(10)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .x_base     (x_base),
        .y_base     (y_base),
        .select     (select),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] cap_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_colour(input int dx, input int dy, input int sel);
        int a;
        int b;
        a = 2 * dx - 11;
        b = 2 * dy - 11;
        if (sel == 0) return GREEN;
        if (sel == 1) return (dx == 0 || dx == 11 || dy == 0 || dy == 11) ? YELLOW : GREEN;
        if (a * a + b * b <= 100) return (sel == 2) ? BLACK : WHITE;
        return GREEN;
    endfunction

    task automatic push_cell(input int xb, input int yb, input int sel);
        for (int dy = 0; dy < 12; dy++)
            for (int dx = 0; dx < 12; dx++)
                exp_q.push_back({8'(xb + dx), 7'(yb + dy), model_colour(dx, dy, sel)});
    endtask

    // Scoreboard consumer: every plotted pixel must match the next expected one.
    always @(negedge clock) begin
        if (!resetn) begin
            if (done) done_cnt++;
            if (vga_plot) begin
                plot_cnt++;
                cap_q.push_back({vga_x, vga_y, vga_colour});
                if (exp_q.size() == 0) check_eq("unexpected_plot", 1, 0);
                else check_eq("pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input int xb, input int yb, input int sel);
        @(negedge clock);
        x_base = 8'(xb);
        y_base = 7'(yb);
        select = 2'(sel);
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        x_base = 8'hA5;
        y_base = 7'h5A;
        select = 2'(sel + 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic run_cell(input string tag, input int xb, input int yb, input int sel);
        int p0;
        push_cell(xb, yb, sel);
        cap_q.delete();
        p0 = plot_cnt;
        issue(xb, yb, sel);
        wait_done(tag);
        #1;
        check_eq({tag, "_plots"}, 32'(plot_cnt - p0), 144);
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    endtask

    function automatic int count_colour(input logic [2:0] c);
        int n;
        n = 0;
        foreach (cap_q[i]) if (cap_q[i][2:0] == c) n++;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        int d0;
        int gold;

        // reset state
        repeat (3) @(negedge clock);
        check_eq("reset_outputs", {vga_x, vga_y, vga_colour, vga_plot, busy, done}, 0);
        resetn = 1'b0;
        repeat (2) @(negedge clock);

        // empty cell with detailed handshake timing
        push_cell(9, 9, 0);
        cap_q.delete();
        p0 = plot_cnt;
        issue(9, 9, 0);
        check_eq("accept_busy_plot", {busy, vga_plot}, 2'b10);
        @(negedge clock);
        check_eq("first_pixel", {vga_x, vga_y, vga_plot}, {8'd9, 7'd9, 1'b1});
        wait_done("empty");
        check_eq("done_cycle", {vga_plot, busy}, 2'b01);
        @(negedge clock);
        check_eq("after_done", {busy, done}, 2'b00);
        #1;
        check_eq("empty_plots", 32'(plot_cnt - p0), 144);
        check_eq("empty_last_xy", cap_q[143][17:3], {8'd20, 7'd20});
        check_eq("empty_green", 32'(count_colour(GREEN)), 144);

        // cursor box
        run_cell("box", 22, 9, 1);
        check_eq("box_0_0", cap_q[0][2:0], YELLOW);
        check_eq("box_11_11", cap_q[143][2:0], YELLOW);
        check_eq("box_1_1", cap_q[13][2:0], GREEN);
        check_eq("box_5_0", cap_q[5], {8'd27, 7'd9, YELLOW});
        check_eq("box_yellow", 32'(count_colour(YELLOW)), 44);

        // black disk
        run_cell("black", 9, 22, 2);
        check_eq("blk_0_0", cap_q[0][2:0], GREEN);
        check_eq("blk_5_5", cap_q[65][2:0], BLACK);
        check_eq("blk_0_5", cap_q[60][2:0], GREEN);
        check_eq("blk_1_5", cap_q[61][2:0], BLACK);
        gold = 0;
        for (int dy = 0; dy < 12; dy++)
            for (int dx = 0; dx < 12; dx++)
                if (model_colour(dx, dy, 2) == BLACK) gold++;
        check_eq("blk_count", 32'(count_colour(BLACK)), 32'(gold));

        // white disk with coordinate wrap
        run_cell("white", 250, 125, 3);
        check_eq("wht_wrap_5_5", cap_q[65], {8'd255, 7'd2, WHITE});
        check_eq("wht_wrap_x", cap_q[6][17:10], 8'd0);

        // start pulses during DRAW and FIN are ignored
        push_cell(40, 40, 2);
        p0 = plot_cnt;
        d0 = done_cnt;
        issue(40, 40, 2);
        repeat (50) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (vga_plot && vga_x == 8'd51 && vga_y == 7'd51) break;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("ign_done", 32'(done), 1);
        repeat (20) @(negedge clock);
        #1;
        check_eq("ign_plots", 32'(plot_cnt - p0), 144);
        check_eq("ign_done_cnt", 32'(done_cnt - d0), 1);
        check_eq("ign_idle", 32'(busy), 0);

        // start held high: back-to-back draws
        push_cell(60, 30, 1);
        push_cell(60, 30, 1);
        p0 = plot_cnt;
        d0 = done_cnt;
        @(negedge clock);
        x_base = 8'd60;
        y_base = 7'd30;
        select = 2'd1;
        start  = 1'b1;
        wait_done("held1");
        @(negedge clock);
        check_eq("held_reaccept", {busy, vga_plot}, 2'b10);
        @(negedge clock);
        check_eq("held_first2", {vga_x, vga_y, vga_plot}, {8'd60, 7'd30, 1'b1});
        start = 1'b0;
        wait_done("held2");
        repeat (10) @(negedge clock);
        #1;
        check_eq("held_plots", 32'(plot_cnt - p0), 288);
        check_eq("held_done_cnt", 32'(done_cnt - d0), 2);
        check_eq("held_idle", 32'(busy), 0);

        // reset mid-scan at pixel 70
        push_cell(100, 50, 0);
        p0 = plot_cnt;
        issue(100, 50, 0);
        repeat (70) @(negedge clock);
        #1;
        check_eq("abort_plots", 32'(plot_cnt - p0), 70);
        d0 = done_cnt;
        resetn = 1'b1;
        #1;
        check_eq("abort_async", {vga_x, vga_y, vga_colour, vga_plot, busy, done}, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        p0 = plot_cnt;
        repeat (200) @(negedge clock);
        #1;
        check_eq("post_reset_plots", 32'(plot_cnt - p0), 0);
        check_eq("post_reset_done", 32'(done_cnt - d0), 0);
        check_eq("post_reset_busy", 32'(busy), 0);
        check_eq("final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_drawer.md
Name: cell_drawer

Overview:
Pixel-level renderer that sits directly downstream of the board datapath. It takes one cell draw request (pixel origin plus a 2-bit select code: empty, cursor box, black disk or white disk) and scans the cell row-major at one pixel per clock. For each pixel it drives coordinate, colour and write-enable into the VGA adapter. A start/busy/done handshake lets the control FSM sequence erase, box and disk operations.

Parameters:
CELL, 12, cell edge in pixels; scan covers CELL x CELL pixels.
DISK_D, 10, disk diameter in pixels; must be <= CELL.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  reset, asynchronous, active-high
start  in  1  draw request; sampled only in IDLE
x_base  in  8  pixel x of cell top-left corner
y_base  in  7  pixel y of cell top-left corner
select  in  2  0 empty, 1 cursor box, 2 black disk, 3 white disk
vga_x  out  8  pixel x to VGA adapter
vga_y  out  7  pixel y to VGA adapter
vga_colour  out  3  RGB colour, 1 bit per channel
vga_plot  out  1  write enable to VGA adapter
busy  out  1  high from the accept edge through the done cycle
done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (async, resetn=1): state IDLE; dx=dy=0; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0. Reset asserted mid-scan aborts immediately; vga_plot drops without waiting for a clock edge.
- States: IDLE, DRAW, FIN.
- IDLE: on an edge with start=1, latch x_base, y_base and select; clear dx and dy; set busy=1; go to DRAW. Inputs are ignored after latching.
- DRAW: each edge registers the following outputs:
  - vga_x = x_base_l + dx (8-bit, wraps mod 256)
  - vga_y = y_base_l + dy (7-bit, wraps mod 128)
  - vga_colour = f(dx, dy, select_l)
  - vga_plot = 1
  Then dx increments. When dx=CELL-1, dx goes to 0 and dy increments. After the pixel (CELL-1, CELL-1) is registered, go to FIN.
- Output timing: the first pixel is valid on the clock after the accept edge. vga_plot is high for exactly CELL*CELL consecutive cycles (144 by default).
- FIN: for one cycle, vga_plot=0, done=1, busy=1. Then go to IDLE with busy=0 and done=0.
- start is ignored while in DRAW or FIN. A start held high is re-accepted on the first IDLE edge.
- Colour function (constants: GREEN=010, YELLOW=110, BLACK=000, WHITE=111):
  - select 0: GREEN for every pixel.
  - select 1: YELLOW where dx or dy is 0 or CELL-1; GREEN elsewhere.
  - select 2/3: compute in doubled coordinates to avoid the half-pixel centre. Let a = 2*dx-(CELL-1) and b = 2*dy-(CELL-1), both signed, at least 6 bits. If a*a + b*b <= DISK_D*DISK_D, output BLACK (select 2) or WHITE (select 3); otherwise GREEN.
- Outside DRAW, vga_x, vga_y and vga_colour hold their last values. Consumers must qualify them with vga_plot.

Decomposition:
- Package othello_draw_pkg holds:
  - colour constants GREEN, YELLOW, BLACK, WHITE
  - select encodings SEL_EMPTY, SEL_BOX, SEL_DISK_B, SEL_DISK_W
  - state encoding for IDLE, DRAW, FIN
- One combinational sub-module, cell_pixel_colour, maps (dx, dy, select) to colour. It carries parameters CELL and DISK_D and is unit-testable on its own.

Test Plan:
- Reset: assert resetn mid-simulation -> all outputs 0 asynchronously, state IDLE; after release with start=0, no vga_plot for 200 cycles.
- Empty cell: start with x_base=9, y_base=9, select=0 -> 144 plot cycles, all colour 010. First pixel (9,9) one cycle after accept; last pixel (20,20). Next cycle done=1, vga_plot=0. Following cycle busy=0.
- Box: base (22,9), select=1 -> (22,9)=110, (33,20)=110, (23,10)=010, (27,9)=110. Total YELLOW count is 44.
- Black disk: base (9,22), select=2 -> offset (0,0)=010; (5,5)=000; (0,5)=010 since 121+1=122>100; (1,5)=000 since 81+1=82<=100. Count of BLACK matches a golden model.
- White disk with wrap: base (250,125), select=3 -> offset (5,5) appears at vga_x=255, vga_y=2 (7-bit wrap from 130) with colour 111; offset (6,0) appears at vga_x=0.
- Handshake: pulse start again during DRAW and during FIN -> ignored, exactly 144 plots. Hold start high continuously -> back-to-back draws, each separated by one FIN cycle and one IDLE-accept edge. Assert resetn at pixel 70 -> vga_plot=0 at once, no done pulse.
